// File: rtl/key_event_scheduler_if.sv
// Key event handshake between the scheduler and the calculator input decoder.
interface key_event_scheduler_if #(
  parameter int CW = 3
);
  logic          keyValid;
  logic          keyReady;
  logic [CW-1:0] keyCode;
  logic          keyRepeat;

  modport master (output keyValid, output keyCode, output keyRepeat, input keyReady);
  modport slave  (input keyValid, input keyCode, input keyRepeat, output keyReady);
endinterface

// File: rtl/key_event_scheduler.sv
// Debounced active-low buttons -> prioritized key events with auto-repeat; press to keyValid is 2 cycles.
// Events stay stable in SEND until keyReady; new presses queue as pending bits meanwhile.
module key_event_scheduler #(
  parameter int width      = 5,
  parameter int freq       = 50000000,
  parameter int holdTime   = 500,
  parameter int repeatTime = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [width-1:0]      debounced,
  key_event_scheduler_if.master evt,
  output logic                  dropped
);
  localparam int CW   = (width > 1) ? $clog2(width) : 1;
  localparam int MS   = (freq / 1000 > 1) ? freq / 1000 : 1;
  localparam int PW   = (MS > 1) ? $clog2(MS) : 1;
  localparam int MAXT = (holdTime > repeatTime) ? holdTime : repeatTime;
  localparam int LW   = $clog2(MAXT + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [width-1:0] prev;
  logic [width-1:0] pending;
  logic [width-1:0] press;
  logic [width-1:0] grant_clr;
  logic [CW-1:0]    low_idx;
  logic             key_valid;
  logic             key_repeat;
  logic [CW-1:0]    key_code;
  logic             grant_key;
  logic             grant_rep;
  logic             accept_fresh;
  logic [CW-1:0]    rep_key;
  logic             rep_armed;
  logic [LW-1:0]    rep_cnt;
  logic [LW-1:0]    rep_limit;
  logic             rep_pending;
  logic             rep_released;
  logic             rep_wrap;

  // Millisecond prescaler
  assign tick = (presc == PW'(MS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) presc <= '0;
    else        presc <= tick ? '0 : presc + 1'b1;
  end

  assign press = prev & ~debounced;

  always_comb begin
    low_idx = '0;
    for (int i = width - 1; i >= 0; i--)
      if (pending[i]) low_idx = CW'(i);
  end

  assign grant_key    = (state == IDLE) && (|pending);
  assign grant_rep    = (state == IDLE) && !(|pending) && rep_pending;
  assign accept_fresh = (state == SEND) && evt.keyReady && !key_repeat;
  assign grant_clr    = grant_key ? ({{(width-1){1'b0}}, 1'b1} << low_idx) : '0;

  // A press on the same edge as the grant-clear re-sets the bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev    <= '1;
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      prev    <= debounced;
      pending <= (pending & ~grant_clr) | press;
      dropped <= |(press & pending);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_repeat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_key) begin
            key_code   <= low_idx;
            key_repeat <= 1'b0;
            key_valid  <= 1'b1;
            state      <= SEND;
          end else if (rep_pending) begin
            key_code   <= rep_key;
            key_repeat <= 1'b1;
            key_valid  <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (evt.keyReady) begin
            key_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rep_released = rep_armed && debounced[rep_key];
  assign rep_wrap     = (rep_cnt == rep_limit - LW'(1));

  // Release beats a same-cycle tick; a fresh acceptance retargets and restarts the hold count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_key     <= '0;
      rep_armed   <= 1'b0;
      rep_cnt     <= '0;
      rep_limit   <= LW'(holdTime);
      rep_pending <= 1'b0;
    end else begin
      if (accept_fresh) begin
        rep_key   <= key_code;
        rep_armed <= 1'b1;
        rep_cnt   <= '0;
        rep_limit <= LW'(holdTime);
      end else if (rep_released) begin
        rep_armed <= 1'b0;
      end else if (rep_armed && tick) begin
        if (rep_wrap) begin
          rep_cnt   <= '0;
          rep_limit <= LW'(repeatTime);
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end

      if (rep_released)                                        rep_pending <= 1'b0;
      else if (rep_armed && tick && rep_wrap && !accept_fresh) rep_pending <= 1'b1;
      else if (grant_rep)                                      rep_pending <= 1'b0;
    end
  end

  assign evt.keyValid  = key_valid;
  assign evt.keyCode   = key_code;
  assign evt.keyRepeat = key_repeat;
endmodule
